risc_lsu: RTL and testbench

RISC_LSU -- requirements
Module: risc_lsu

---
 rtl/risc_lsu.sv | 165 ++++++++++++++++
 tb/tb_risc_lsu.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_lsu.sv
// Load/store unit: one data-memory access per start pulse, byte/half/word lanes, ack timeout.
// Optional misaligned-access trap is enabled by defining RISC_LSU_MISALIGN_CHK_EN.
module risc_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_lane;
    logic        err_q;
    logic [31:0] rd_data_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Request decode from the core inputs, used only when a start is accepted.
    logic        f3_ok;
    logic        misalign;
    logic [1:0]  lane;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        f3_ok    = 1'b0;
        misalign = 1'b0;
        lane     = addr[1:0];
        be_n     = 4'b0000;
        wdata_n  = wr_data;
        case (funct3)
            3'b000, 3'b100: begin
                be_n    = 4'b0001 << addr[1:0];
                wdata_n = {4{wr_data[7:0]}};
                f3_ok   = !(mem_write && funct3[2]);
            end
            3'b001, 3'b101: begin
                lane    = {addr[1], 1'b0};
                be_n    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_n = {2{wr_data[15:0]}};
                f3_ok   = !(mem_write && funct3[2]);
`ifdef RISC_LSU_MISALIGN_CHK_EN
                misalign = addr[0];
`endif
            end
            3'b010: begin
                lane    = 2'b00;
                be_n    = 4'b1111;
                wdata_n = wr_data;
                f3_ok   = 1'b1;
`ifdef RISC_LSU_MISALIGN_CHK_EN
                misalign = (addr[1:0] != 2'b00);
`endif
            end
            default: f3_ok = 1'b0;
        endcase
    end

    // Lane extraction and sign/zero extension of the returning load data.
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    always_comb begin
        byte_sel = dmem_rdata[8*lat_lane +: 8];
        half_sel = lat_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_f3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = dmem_rdata;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            lat_f3    <= 3'b000;
            lat_lane  <= 2'b00;
            err_q     <= 1'b0;
            rd_data_q <= 32'h0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lat_f3   <= funct3;
                        lat_lane <= lane;
                        we_q     <= mem_write;
                        be_q     <= be_n;
                        addr_q   <= {addr[31:2], 2'b00};
                        wdata_q  <= wdata_n;
                        cnt      <= 8'd0;
                        if (!f3_ok || misalign) begin
                            state <= S_DONE;
                            err_q <= 1'b1;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    // An ack arriving on the last allowed cycle still wins over the timeout.
                    if (dmem_ack) begin
                        state <= S_DONE;
                        if (!we_q) rd_data_q <= load_val;
                    end else if (cnt == CNT_LAST) begin
                        state     <= S_DONE;
                        err_q     <= 1'b1;
                        rd_data_q <= 32'h0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    err_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign err        = err_q;
    assign rd_data    = rd_data_q;
    assign dmem_req   = (state == S_REQ);
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_risc_lsu.sv
// Directed bench for risc_lsu: lane steering, extension, timeout, illegal/misaligned, reset abort.
`timescale 1ns/1ps
module tb_risc_lsu;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rd_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    risc_lsu #(.DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_data    (rd_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_be    (dmem_be),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one start pulse; returns 1ns after the edge that accepted it.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        start     = 1'b1;
        mem_write = we;
        funct3    = f3;
        addr      = a;
        wr_data   = wd;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        n_checks++;
        if ({busy, done, err, dmem_req, dmem_we, dmem_be} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {busy, done, err, dmem_req, dmem_we, dmem_be});
        end
        n_checks++;
        if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        n_checks++;
        if (dmem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", dmem_addr); end
        n_checks++;
        if (dmem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", dmem_wdata); end
    endtask

    task automatic test_lb();
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        n_checks++;
        if ({dmem_req, dmem_we, dmem_be} !== 6'b1_0_1000) begin
            n_fail++; $display("FAIL lb_req: got %b expected 101000", {dmem_req, dmem_we, dmem_be});
        end
        n_checks++;
        if (dmem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL lb_addr: got %h expected 00000100", dmem_addr); end
        tick();
        dmem_rdata = 32'h80FF_1234;
        dmem_ack   = 1'b1;
        n_checks++;
        if (dmem_req !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL lb_wait: req=%b done=%b expected req=1 done=0", dmem_req, done);
        end
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if ({done, err, dmem_req} !== 3'b100) begin
            n_fail++; $display("FAIL lb_done: done/err/req=%b expected 100", {done, err, dmem_req});
        end
        n_checks++;
        if (rd_data !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", rd_data); end
        tick();
        n_checks++;
        if ({done, busy} !== 2'b00 || rd_data !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb_hold: done/busy=%b rd=%h expected 00 ffffff80", {done, busy}, rd_data);
        end
    endtask

    task automatic test_halfword();
        issue(1'b0, 3'b101, 32'h0000_0102, 32'h0);
        n_checks++;
        if (dmem_be !== 4'b1100) begin n_fail++; $display("FAIL lhu_be: got %b expected 1100", dmem_be); end
        dmem_rdata = 32'hBEEF_0000;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if (done !== 1'b1 || rd_data !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL lhu_data: done=%b rd=%h expected 1 0000beef", done, rd_data);
        end
        tick();
        issue(1'b0, 3'b001, 32'h0000_0100, 32'h0);
        n_checks++;
        if (dmem_be !== 4'b0011) begin n_fail++; $display("FAIL lh_be: got %b expected 0011", dmem_be); end
        dmem_rdata = 32'h1234_8001;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if (rd_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_data: got %h expected ffff8001", rd_data); end
        tick();
    endtask

    task automatic test_store();
        issue(1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB);
        // Core inputs change mid-access; the request must not follow them.
        addr    = 32'hFFFF_FFFF;
        wr_data = 32'h0;
        funct3  = 3'b010;
        tick();
        n_checks++;
        if ({dmem_req, dmem_we, dmem_be} !== 6'b1_1_0010) begin
            n_fail++; $display("FAIL sb_req: got %b expected 110010", {dmem_req, dmem_we, dmem_be});
        end
        n_checks++;
        if (dmem_addr !== 32'h0000_0200 || dmem_wdata !== 32'hABAB_ABAB) begin
            n_fail++; $display("FAIL sb_bus: addr=%h wdata=%h expected 00000200 abababab", dmem_addr, dmem_wdata);
        end
        dmem_rdata = 32'h5555_5555;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if ({done, err} !== 2'b10 || rd_data !== 32'hFFFF_8001) begin
            n_fail++; $display("FAIL sb_done: done/err=%b rd=%h expected 10 ffff8001", {done, err}, rd_data);
        end
        tick();
        issue(1'b1, 3'b001, 32'h0000_0202, 32'h0000_CAFE);
        n_checks++;
        if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hCAFE_CAFE) begin
            n_fail++; $display("FAIL sh_bus: be=%b wdata=%h expected 1100 cafecafe", dmem_be, dmem_wdata);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        tick();
        issue(1'b1, 3'b010, 32'h0000_0300, 32'hA5A5_0F0F);
        n_checks++;
        if (dmem_be !== 4'b1111 || dmem_wdata !== 32'hA5A5_0F0F) begin
            n_fail++; $display("FAIL sw_bus: be=%b wdata=%h expected 1111 a5a50f0f", dmem_be, dmem_wdata);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        while (dmem_req === 1'b1 && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        n_checks++;
        if (req_cycles != 16) begin n_fail++; $display("FAIL timeout_len: got %0d req cycles expected 16", req_cycles); end
        n_checks++;
        if ({done, err} !== 2'b11 || rd_data !== 32'h0) begin
            n_fail++; $display("FAIL timeout_done: done/err=%b rd=%h expected 11 0", {done, err}, rd_data);
        end
        tick();
        n_checks++;
        if ({done, err, busy} !== 3'b000) begin
            n_fail++; $display("FAIL timeout_clear: done/err/busy=%b expected 000", {done, err, busy});
        end
    endtask

    task automatic test_misalign();
`ifdef RISC_LSU_MISALIGN_CHK_EN
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        n_checks++;
        if ({dmem_req, done, err} !== 3'b011 || rd_data !== 32'h0) begin
            n_fail++; $display("FAIL lw_misalign: req/done/err=%b rd=%h expected 011 0", {dmem_req, done, err}, rd_data);
        end
        tick();
`else
        issue(1'b0, 3'b010, 32'h0000_0102, 32'h0);
        n_checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0100 || dmem_be !== 4'b1111) begin
            n_fail++; $display("FAIL lw_unaligned_req: req=%b addr=%h be=%b expected 1 00000100 1111", dmem_req, dmem_addr, dmem_be);
        end
        dmem_rdata = 32'hDEAD_BEEF;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if ({done, err} !== 2'b10 || rd_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL lw_unaligned_data: done/err=%b rd=%h expected 10 deadbeef", {done, err}, rd_data);
        end
        tick();
`endif
    endtask

    task automatic test_illegal();
        issue(1'b0, 3'b011, 32'h0000_0500, 32'h0);
        n_checks++;
        if ({dmem_req, done, err} !== 3'b011) begin
            n_fail++; $display("FAIL illegal_load: req/done/err=%b expected 011", {dmem_req, done, err});
        end
        tick();
        issue(1'b1, 3'b100, 32'h0000_0500, 32'h0);
        n_checks++;
        if ({dmem_req, done, err} !== 3'b011) begin
            n_fail++; $display("FAIL illegal_store: req/done/err=%b expected 011", {dmem_req, done, err});
        end
        tick();
        // Stray ack while idle must not start or finish anything.
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if ({busy, done, dmem_req} !== 3'b000) begin
            n_fail++; $display("FAIL idle_ack: busy/done/req=%b expected 000", {busy, done, dmem_req});
        end
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 3'b000, 32'h0000_0600, 32'h0);
        start = 1'b1;
        addr  = 32'h0000_0704;
        tick();
        start = 1'b0;
        n_checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0600) begin
            n_fail++; $display("FAIL busy_start: req=%b addr=%h expected 1 00000600", dmem_req, dmem_addr);
        end
        dmem_rdata = 32'h0000_007F;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if (done !== 1'b1 || rd_data !== 32'h0000_007F) begin
            n_fail++; $display("FAIL b2b_data: done=%b rd=%h expected 1 0000007f", done, rd_data);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        bit saw_done = 1'b0;
        issue(1'b0, 3'b000, 32'h0000_0800, 32'h0);
        tick();
        tick();
        nrst = 1'b0;
        n_checks++;
        if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL abort_pre: req=%b expected 1", dmem_req); end
        tick();
        nrst = 1'b1;
        n_checks++;
        if ({dmem_req, busy, done} !== 3'b000) begin
            n_fail++; $display("FAIL abort_drop: req/busy/done=%b expected 000", {dmem_req, busy, done});
        end
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_done) begin n_fail++; $display("FAIL abort_done: got done after reset expected none"); end
        issue(1'b0, 3'b100, 32'h0000_0101, 32'h0);
        n_checks++;
        if (dmem_be !== 4'b0010) begin n_fail++; $display("FAIL lbu_be: got %b expected 0010", dmem_be); end
        dmem_rdata = 32'h0000_9A00;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack = 1'b0;
        n_checks++;
        if ({done, err} !== 2'b10 || rd_data !== 32'h0000_009A) begin
            n_fail++; $display("FAIL lbu_data: done/err=%b rd=%h expected 10 0000009a", {done, err}, rd_data);
        end
        tick();
    endtask

    initial begin
        nrst       = 1'b0;
        start      = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        wr_data    = 32'h0;
        dmem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        test_reset();
        test_lb();
        test_halfword();
        test_store();
        test_timeout();
        test_misalign();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
